// File: rtl/background_color_fetch.sv
// Background colour fetch: per pixel tick, reads the 9-bit block colour through a req/grant port
// and presents it registered before the next tick; overlapping ticks abort the fetch and flag underrun.
module background_color_fetch #(
  parameter int         BLOCK_SHIFT    = 3,
  parameter int         BLOCKS_PER_ROW = 80,
  parameter int         H_ACTIVE       = 640,
  parameter int         V_ACTIVE       = 480,
  parameter int         ADDR_W         = 13,
  parameter int         MEM_LATENCY    = 1,
  parameter logic [8:0] TRANSPARENT    = 9'h1FF,
  parameter logic [8:0] DEFAULT_COLOR  = 9'h000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_tick,
  input  logic [9:0]        new_px,
  input  logic [9:0]        new_py,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_grant,
  input  logic [8:0]        mem_data,
  output logic [8:0]        color_out,
  output logic              color_valid,
  output logic              underrun,
  input  logic              clear_underrun
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [9:0] H_LIM    = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM    = 10'(V_ACTIVE);
  localparam logic [1:0] CNT_LOAD = 2'(MEM_LATENCY - 1);

  state_t            state_q;
  logic              pend_q;
  logic [9:0]        px_q, py_q;
  logic [1:0]        cnt_q;

  logic [9:0]        cur_px, cur_py;
  logic              cur_active;
  logic [ADDR_W-1:0] cur_addr;

  // A live tick takes its coordinates straight from the ports; a tick deferred by an overrun
  // replays the coordinates captured when it arrived.
  always_comb begin
    cur_px     = pixel_tick ? new_px : px_q;
    cur_py     = pixel_tick ? new_py : py_q;
    cur_active = (cur_px < H_LIM) && (cur_py < V_LIM);
    cur_addr   = ADDR_W'(cur_py >> BLOCK_SHIFT) * ADDR_W'(BLOCKS_PER_ROW)
               + ADDR_W'(cur_px >> BLOCK_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      px_q        <= '0;
      py_q        <= '0;
      cnt_q       <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      color_out   <= DEFAULT_COLOR;
      color_valid <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (pixel_tick) begin
        px_q <= new_px;
        py_q <= new_py;
      end
      if (clear_underrun) underrun <= 1'b0;

      case (state_q)
        IDLE: begin
          if (pixel_tick || pend_q) begin
            pend_q <= 1'b0;
            if (cur_active) begin
              mem_addr    <= cur_addr;
              mem_req     <= 1'b1;
              color_valid <= 1'b0;
              state_q     <= REQ;
            end else begin
              color_out   <= DEFAULT_COLOR;
              color_valid <= 1'b1;
            end
          end
        end
        REQ, WAIT: begin
          if (pixel_tick) begin
            // Slot overrun: the missed pixel gets the default colour, new tick replays next cycle.
            underrun    <= 1'b1;
            mem_req     <= 1'b0;
            color_out   <= DEFAULT_COLOR;
            color_valid <= 1'b1;
            pend_q      <= 1'b1;
            state_q     <= IDLE;
          end else if (state_q == REQ) begin
            if (mem_grant) begin
              mem_req <= 1'b0;
              cnt_q   <= CNT_LOAD;
              state_q <= WAIT;
            end
          end else if (cnt_q == 2'd0) begin
            color_out   <= (mem_data == TRANSPARENT) ? DEFAULT_COLOR : mem_data;
            color_valid <= 1'b1;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
